uart_transmitter: RTL
=====================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter TICKS_PER_BIT, default 16, meaning baud ticks per serial bit (matches the receiver's 16x oversampling).
REQ-002 reset  input  1  asynchronous, active-high; returns the block to IDLE.
REQ-003 clk  input  1  system clock, 50 MHz; all state changes on its rising edge.
REQ-004 Tx_DATA  input  8  byte to send, sampled only on an accepted write.
REQ-005 baud_select  input  3  rate: 000=300, 001=1200, 010=4800, 011=9600, 100=19200, 101=38400, 110=57600, 111=115200 baud.
REQ-006 Tx_EN  input  1  transmitter enable; low forces IDLE.
REQ-007 Tx_WR  input  1  one-clk write strobe.
REQ-008 TxD  output  1  serial line, idle high, registered.
REQ-009 Tx_BUSY  output  1  high while a frame is in progress, registered.

Function
REQ-010 The internal tick divider SHALL assert a one-clk baud tick every DIV clks: DIV = 10417, 2604, 651, 326, 163, 81, 54, 27 for baud_select 000..111.
REQ-011 The frame SHALL be: start(0), D0..D7 LSB first, parity, stop(1), 11 bits, each held exactly TICKS_PER_BIT ticks.
REQ-012 The parity bit SHALL be even parity: XOR of all 8 data bits, so data bits plus parity hold an even number of ones.
REQ-013 States SHALL be IDLE, START, DATA (3-bit bit index 0..7), PARITY, STOP.
REQ-014 IDLE -> START on the clk edge where Tx_EN=1, Tx_WR=1, Tx_BUSY=0; on that edge:
- Tx_DATA latched into a shift register
- TxD=0, Tx_BUSY=1
- divider and tick counter cleared
REQ-015 Tx_WR while Tx_BUSY=1 or Tx_EN=0 SHALL be ignored; latched data SHALL not change.
REQ-016 Each state SHALL advance after TICKS_PER_BIT ticks: START->DATA(0), DATA(i)->DATA(i+1), DATA(7)->PARITY, PARITY->STOP, STOP->IDLE.
REQ-017 TxD SHALL change only on the state-advance edge; it SHALL not glitch within a bit.
REQ-018 Tx_BUSY SHALL fall on the edge STOP->IDLE, exactly 11*TICKS_PER_BIT*DIV clks after the accepting edge.
REQ-019 A write SHALL be accepted on the first edge with Tx_BUSY=0, which allows back-to-back frames with no idle gap.
REQ-020 The tick counter SHALL be 4 bits and wrap 15->0 on the advancing tick.
REQ-021 baud_select changes while Tx_BUSY=1 SHALL take effect only at the next accepted write; the divider value is latched at acceptance.
REQ-022 Tx_EN low at any clk edge mid-frame SHALL abort to IDLE on that edge with TxD=1 and Tx_BUSY=0.
REQ-023 Tx_WR and Tx_EN rising on the same edge SHALL be accepted.

Reset
REQ-024 While reset=1 and after its release, the block SHALL hold:
- TxD=1, Tx_BUSY=0, state IDLE
- divider, tick counter, bit index and shift register all 0
REQ-025 Reset asserted mid-frame SHALL take effect immediately (asynchronously), with no partial bit completed.
REQ-026 The first write SHALL be accepted on the first clk edge after reset deasserts.

Verification
REQ-027 Write 0x55 at baud_select=011 -> TxD sequence 0,1,0,1,0,1,0,1,0,0(parity),1(stop), each bit 5216 clks; Tx_BUSY high for 57376 clks.
REQ-028 Write 0xA7 at 111 -> bits 0,1,1,1,0,0,1,0,1,1(parity),1, each bit 432 clks.
REQ-029 Write 0x3C, then a second Tx_WR with 0xFF 1000 clks later -> the second write is ignored, the frame carries 0x3C, and Tx_BUSY falls once.
REQ-030 Write 0x00 at 111, reset pulsed during D3 -> TxD=1 and Tx_BUSY=0 immediately; a new write of 0x81 then sends a clean frame with parity 0.
REQ-031 Tx_EN dropped during PARITY -> TxD=1 and Tx_BUSY=0 on the next edge, with no stop bit emitted.
REQ-032 Loopback of TxD into uart_receiver, both at 100, bytes 0x00, 0xFF, 0x5A sent back-to-back -> Rx_DATA matches each byte, Rx_VALID=1, Rx_PERROR=0, Rx_FERROR=0.

Source files
------------

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - 8E1 UART transmitter with selectable baud divider and TICKS_PER_BIT ticks per bit.
module uart_transmitter #(
   parameter int TICKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] Tx_DATA,
   input  logic [2:0] baud_select,
   input  logic       Tx_EN,
   input  logic       Tx_WR,
   output logic       TxD,
   output logic       Tx_BUSY
);

   localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t          state_q;
   logic [13:0]     div_d;
   logic [13:0]     div_q;
   logic [13:0]     div_cnt_q;
   logic [TW-1:0]   tick_cnt_q;
   logic [2:0]      bit_q;
   logic [7:0]      data_q;
   logic            baud_tick;
   logic            bit_done;

   always_comb begin
      div_d = 14'd10417;
      case (baud_select)
         3'b000:  div_d = 14'd10417;
         3'b001:  div_d = 14'd2604;
         3'b010:  div_d = 14'd651;
         3'b011:  div_d = 14'd326;
         3'b100:  div_d = 14'd163;
         3'b101:  div_d = 14'd81;
         3'b110:  div_d = 14'd54;
         default: div_d = 14'd27;
      endcase
   end

   assign baud_tick = (div_cnt_q == div_q - 14'd1);
   assign bit_done  = baud_tick && (tick_cnt_q == TICK_LAST);

   // Divider value is captured at acceptance so baud_select may change mid-frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         div_q      <= '0;
         div_cnt_q  <= '0;
         tick_cnt_q <= '0;
         bit_q      <= '0;
         data_q     <= '0;
         TxD        <= 1'b1;
         Tx_BUSY    <= 1'b0;
      end else if (!Tx_EN) begin
         state_q    <= IDLE;
         div_cnt_q  <= '0;
         tick_cnt_q <= '0;
         bit_q      <= '0;
         TxD        <= 1'b1;
         Tx_BUSY    <= 1'b0;
      end else if (state_q == IDLE) begin
         if (Tx_WR) begin
            state_q    <= START;
            data_q     <= Tx_DATA;
            div_q      <= div_d;
            div_cnt_q  <= '0;
            tick_cnt_q <= '0;
            bit_q      <= '0;
            TxD        <= 1'b0;
            Tx_BUSY    <= 1'b1;
         end
      end else begin
         if (baud_tick) begin
            div_cnt_q  <= '0;
            tick_cnt_q <= bit_done ? '0 : tick_cnt_q + TW'(1);
         end else begin
            div_cnt_q  <= div_cnt_q + 14'd1;
         end
         if (bit_done) begin
            case (state_q)
               START: begin
                  state_q <= DATA;
                  bit_q   <= 3'd0;
                  TxD     <= data_q[0];
               end
               DATA: begin
                  if (bit_q == 3'd7) begin
                     state_q <= PARITY;
                     TxD     <= ^data_q;
                  end else begin
                     bit_q   <= bit_q + 3'd1;
                     TxD     <= data_q[bit_q + 3'd1];
                  end
               end
               PARITY: begin
                  state_q <= STOP;
                  TxD     <= 1'b1;
               end
               default: begin
                  state_q <= IDLE;
                  TxD     <= 1'b1;
                  Tx_BUSY <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
